// File: rtl/ooo_config_pkg.sv
// Machine-wide out-of-order core sizing constants shared by the issue-side blocks.
package ooo_config;
  localparam int unsigned PREG_BITS   = 6;
  localparam int unsigned ROB_BITS    = 5;
  localparam int unsigned BRU_NUM     = 4;
  localparam int unsigned CDB_PORTS   = 4;
  localparam int unsigned BR_IDX_BITS = $clog2(BRU_NUM);
endpackage

// File: rtl/rv32i_types_pkg.sv
// RV32 micro-op types shared between dispatch, the divide reservation station and the divider.
package rv32i_types;
  import ooo_config::*;

  typedef logic [BRU_NUM-1:0] br_mask;

  // Values match the M-extension funct3 encodings.
  typedef enum logic [2:0] {
    F3Div  = 3'b100,
    F3Divu = 3'b101,
    F3Rem  = 3'b110,
    F3Remu = 3'b111
  } div_f3_t;

  typedef struct packed {
    logic [PREG_BITS-1:0] ps1;
    logic [PREG_BITS-1:0] ps2;
    logic                 ps1_rdy;
    logic                 ps2_rdy;
    logic [ROB_BITS-1:0]  rob_idx;
    logic [4:0]           rd;
    logic [PREG_BITS-1:0] pd;
    div_f3_t              divop;
    br_mask               branch_mask;
  } div_rs_entry_t;
endpackage

// File: rtl/rs_age_matrix.sv
// Age matrix for a reservation station: grants the oldest requesting slot (one-hot).
module rs_age_matrix #(
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DEPTH-1:0] alloc,
  input  logic [DEPTH-1:0] free,
  input  logic [DEPTH-1:0] req,
  output logic [DEPTH-1:0] grant
);
  // older_q[i][j] set means slot i is older than slot j.
  logic [DEPTH-1:0] older_q [DEPTH];
  logic [DEPTH-1:0] older_d [DEPTH];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      older_d[i] = older_q[i];
      for (int j = 0; j < DEPTH; j++) begin
        if (alloc[i] || free[i]) begin
          older_d[i][j] = 1'b0;
        end else if (alloc[j]) begin
          older_d[i][j] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      grant[i] = req[i];
      for (int j = 0; j < DEPTH; j++) begin
        if (req[j] && older_q[j][i]) grant[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      older_q <= '{default: '0};
    end else begin
      older_q <= older_d;
    end
  end
endmodule

// File: rtl/div_resv_station.sv
// Divide-unit reservation station: holds DIV/REM micro-ops until sources wake, issues oldest ready.
// Define DIV_RESV_PERF_EN to add saturating full-stall and issue counters.
module div_resv_station
  import ooo_config::*;
  import rv32i_types::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           disp_valid,
  output logic                           disp_ready,
  input  div_rs_entry_t                  disp_entry,
  input  logic [CDB_PORTS-1:0]           cdb_valid,
  input  logic [CDB_PORTS*PREG_BITS-1:0] cdb_pd,
  input  logic                           br_valid,
  input  logic                           br_mispred,
  input  logic [BR_IDX_BITS-1:0]         br_idx,
  output logic                           div_issue,
  output div_rs_entry_t                  div_entry,
  output logic [PREG_BITS-1:0]           regf_ps1,
  output logic [PREG_BITS-1:0]           regf_ps2
`ifdef DIV_RESV_PERF_EN
  ,
  output logic [31:0]                    perf_full_cycles,
  output logic [31:0]                    perf_issues
`endif
);
  div_rs_entry_t    entries_q [DEPTH];
  div_rs_entry_t    entries_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] free_slot, alloc, free, cand, grant;
  logic             found, squash, disp_fire, sel_kill;
  div_rs_entry_t    sel_entry, new_entry;

  function automatic logic woken(input logic [PREG_BITS-1:0] tag,
                                 input logic [CDB_PORTS-1:0] vld,
                                 input logic [CDB_PORTS*PREG_BITS-1:0] pds);
    logic hit;
    hit = (tag == '0);
    for (int p = 0; p < CDB_PORTS; p++) begin
      if (vld[p] && (pds[p*PREG_BITS +: PREG_BITS] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

  assign squash     = br_valid & br_mispred;
  assign disp_ready = ~&valid_q;
  assign disp_fire  = disp_valid & disp_ready & ~(squash & disp_entry.branch_mask[br_idx]);
  assign alloc      = disp_fire ? free_slot : '0;

  always_comb begin
    free_slot = '0;
    found     = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!valid_q[i] && !found) begin
        free_slot[i] = 1'b1;
        found        = 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      cand[i] = valid_q[i] & entries_q[i].ps1_rdy & entries_q[i].ps2_rdy;
    end
  end

  rs_age_matrix #(.DEPTH(DEPTH)) u_age (
    .clk   (clk),
    .rst   (rst),
    .alloc (alloc),
    .free  (free),
    .req   (cand),
    .grant (grant)
  );

  always_comb begin
    sel_entry = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant[i]) sel_entry = entries_q[i];
    end
    // A mispredict hitting the oldest candidate kills the whole issue slot this cycle.
    sel_kill  = squash & sel_entry.branch_mask[br_idx];
    div_issue = (|grant) & ~sel_kill & ~rst;
    div_entry = sel_entry;
    if (br_valid) div_entry.branch_mask[br_idx] = 1'b0;
    regf_ps1  = sel_entry.ps1;
    regf_ps2  = sel_entry.ps2;
    free      = div_issue ? grant : '0;
  end

  always_comb begin
    new_entry = disp_entry;
    new_entry.ps1_rdy = disp_entry.ps1_rdy | woken(disp_entry.ps1, cdb_valid, cdb_pd);
    new_entry.ps2_rdy = disp_entry.ps2_rdy | woken(disp_entry.ps2, cdb_valid, cdb_pd);
    if (br_valid && !br_mispred) new_entry.branch_mask[br_idx] = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      entries_d[i] = entries_q[i];
      entries_d[i].ps1_rdy = entries_q[i].ps1_rdy | woken(entries_q[i].ps1, cdb_valid, cdb_pd);
      entries_d[i].ps2_rdy = entries_q[i].ps2_rdy | woken(entries_q[i].ps2, cdb_valid, cdb_pd);
      if (br_valid && !br_mispred) entries_d[i].branch_mask[br_idx] = 1'b0;
      valid_d[i] = valid_q[i] & ~free[i] & ~(squash & entries_q[i].branch_mask[br_idx]);
      if (alloc[i]) begin
        entries_d[i] = new_entry;
        valid_d[i]   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Payload needs no reset; valid_q qualifies every use.
  always_ff @(posedge clk) begin
    entries_q <= entries_d;
  end

`ifdef DIV_RESV_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_full_cycles <= '0;
      perf_issues      <= '0;
    end else begin
      if (disp_valid && !disp_ready && (perf_full_cycles != '1)) begin
        perf_full_cycles <= perf_full_cycles + 32'd1;
      end
      if (div_issue && (perf_issues != '1)) begin
        perf_issues <= perf_issues + 32'd1;
      end
    end
  end
`endif
endmodule
